// File: rtl/mesm6_pkg.sv
// Shared types and helpers for the MESM-6 bit-field pack/unpack sequencer.
package mesm6_pkg;

   localparam int WORD_W = 48;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {
      OP_PACK   = 1'b0,
      OP_UNPACK = 1'b1
   } bitop_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Number of set bits in a 48-bit word (0..48 fits in 6 bits).
   function automatic logic [5:0] popcount48(input word_t w);
      logic [5:0] c;
      c = 6'd0;
      for (int i = 0; i < WORD_W; i++) begin
         c = c + {5'd0, w[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/mesm6_bitfield_step.sv
// One mask position of the serial pack/unpack datapath.
// PACK:   src holds the source word unchanged; a selected bit src[pos] is
//         shifted into the result from the top.
// UNPACK: src is the consumable source word; a selected position takes
//         src[47], places it at result[pos] and shifts src left.
module mesm6_bitfield_step
   import mesm6_pkg::*;
(
   input  bitop_t     op_i,
   input  logic       mbit_i,
   input  logic [5:0] pos_i,
   input  word_t      src_i,
   input  word_t      res_i,
   output word_t      src_o,
   output word_t      res_o
);

   logic pick_s;

   // Selected source bit for PACK at the current scan position.
   assign pick_s = src_i[pos_i];

   // Apply one scan step; an unselected position leaves both registers as they are.
   always_comb begin
      src_o = src_i;
      res_o = res_i;
      if (mbit_i) begin
         case (op_i)
            OP_PACK: begin
               res_o = {pick_s, res_i[WORD_W-1:1]};
            end
            OP_UNPACK: begin
               res_o = res_i | ({47'd0, src_i[WORD_W-1]} << pos_i);
               src_o = {src_i[WORD_W-2:0], 1'b0};
            end
            default: begin
               res_o = res_i;
            end
         endcase
      end else begin
         res_o = res_i;
      end
   end

endmodule

// File: rtl/mesm6_bitfield_seq.sv
// Multicycle MESM-6 pack/unpack sequencer: scans the mask one position per
// clock and builds the 48-bit result serially behind valid/ready handshakes.
module mesm6_bitfield_seq
   import mesm6_pkg::*;
#(
   parameter bit EARLY_EXIT = 1'b1
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_op,
   input  logic [47:0] req_val,
   input  logic [47:0] req_mask,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [47:0] rsp_data,
   output logic [5:0]  rsp_count,
   output logic        busy
);

   state_t     state_q, state_d;
   bitop_t     op_q, op_d;
   logic [5:0] ptr_q, ptr_d;
   word_t      rem_q, rem_d;
   word_t      src_q, src_d;
   word_t      res_q, res_d;
   logic [5:0] cnt_q, cnt_d;

   word_t      step_src_s;
   word_t      step_res_s;
   word_t      rem_step_s;
   logic       last_pos_s;

   mesm6_bitfield_step u_step (
      .op_i   (op_q),
      .mbit_i (rem_q[ptr_q]),
      .pos_i  (ptr_q),
      .src_i  (src_q),
      .res_i  (res_q),
      .src_o  (step_src_s),
      .res_o  (step_res_s)
   );

   // Remaining mask with the current position retired.
   assign rem_step_s = rem_q & ~(48'd1 << ptr_q);
   // PACK ends on position 47 (counting up), UNPACK on position 0 (counting down).
   assign last_pos_s = (op_q == OP_PACK) ? (ptr_q == 6'd47) : (ptr_q == 6'd0);

   assign rsp_data  = res_q;
   assign rsp_count = cnt_q;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept, scan until the last useful position, hand off result.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_mask == 48'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            if (last_pos_s || (EARLY_EXIT && (rem_step_s == 48'd0))) begin
               state_d = S_DONE;
            end else begin
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Handshake outputs decoded from the state register.
   always_comb begin
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      busy      = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
         end
         S_RUN: begin
            busy = 1'b1;
         end
         S_DONE: begin
            rsp_valid = 1'b1;
            busy      = 1'b1;
         end
         default: begin
            req_ready = 1'b0;
         end
      endcase
   end

   // Datapath next values: load on acceptance, step once per RUN cycle, hold otherwise.
   always_comb begin
      op_d  = op_q;
      ptr_d = ptr_q;
      rem_d = rem_q;
      src_d = src_q;
      res_d = res_q;
      cnt_d = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d  = bitop_t'(req_op);
               ptr_d = req_op ? 6'd47 : 6'd0;
               rem_d = req_mask;
               src_d = req_val;
               res_d = 48'd0;
               cnt_d = popcount48(req_mask);
            end else begin
               ptr_d = ptr_q;
            end
         end
         S_RUN: begin
            rem_d = rem_step_s;
            src_d = step_src_s;
            res_d = step_res_s;
            if (op_q == OP_PACK) begin
               ptr_d = ptr_q + 6'd1;
            end else begin
               ptr_d = ptr_q - 6'd1;
            end
         end
         default: begin
            ptr_d = ptr_q;
         end
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q  <= OP_PACK;
         ptr_q <= 6'd0;
         rem_q <= 48'd0;
         src_q <= 48'd0;
         res_q <= 48'd0;
         cnt_q <= 6'd0;
      end else begin
         op_q  <= op_d;
         ptr_q <= ptr_d;
         rem_q <= rem_d;
         src_q <= src_d;
         res_q <= res_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mesm6_bitfield_seq.sv
// Directed bench for mesm6_bitfield_seq: an early-exit and a full-scan
// instance share the request side and are checked side by side.
module tb_mesm6_bitfield_seq;
   import mesm6_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_op;
   logic [47:0] req_val;
   logic [47:0] req_mask;
   logic        rsp_ready;

   logic        rr_e, rv_e, busy_e;
   logic [47:0] rd_e;
   logic [5:0]  rc_e;
   logic        rr_n, rv_n, busy_n;
   logic [47:0] rd_n;
   logic [5:0]  rc_n;

   int n_vec;
   int n_bad;

   mesm6_bitfield_seq #(.EARLY_EXIT(1'b1)) dut_e (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(rr_e), .req_op(req_op),
      .req_val(req_val), .req_mask(req_mask),
      .rsp_valid(rv_e), .rsp_ready(rsp_ready),
      .rsp_data(rd_e), .rsp_count(rc_e), .busy(busy_e)
   );

   mesm6_bitfield_seq #(.EARLY_EXIT(1'b0)) dut_n (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(rr_n), .req_op(req_op),
      .req_val(req_val), .req_mask(req_mask),
      .rsp_valid(rv_n), .rsp_ready(rsp_ready),
      .rsp_data(rd_n), .rsp_count(rc_n), .busy(busy_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic  op;
      word_t val;
      word_t mask;
      word_t data;
      int    cnt;
      int    lat_e;
      int    lat_n;
   } vec_t;

   vec_t tbl[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference PACK: walk the mask from the top, filling the result from bit 47 down.
   function automatic word_t model_pack(input word_t v, input word_t m);
      word_t r;
      int    k;
      r = 48'd0;
      k = 47;
      for (int i = 47; i >= 0; i--) begin
         if (m[i]) begin
            r[k] = v[i];
            k--;
         end
      end
      return r;
   endfunction

   function automatic int model_lat(input logic op, input word_t m);
      int hi, lo;
      hi = -1;
      lo = 48;
      for (int i = 0; i < 48; i++) begin
         if (m[i]) begin
            if (i > hi) hi = i;
            if (i < lo) lo = i;
         end
      end
      if (m == 48'd0) return 0;
      return op ? (48 - lo) : (hi + 1);
   endfunction

   task automatic wait_idle(input string name);
      int g;
      g = 0;
      while (!(rr_e && rr_n) && g < 200) begin
         @(posedge clk); #1;
         g++;
      end
      chk({name, " idle"}, {63'd0, rr_e & rr_n}, 64'd1);
   endtask

   task automatic run_txn(input string name, input logic op, input word_t val, input word_t mask,
                          input word_t exp_d, input int exp_c, input int exp_le, input int exp_ln,
                          output word_t got);
      int         k, le, ln;
      word_t      de, dn;
      logic [5:0] ce, cn;
      wait_idle(name);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = op;
      req_val   = val;
      req_mask  = mask;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      k = 0; le = -1; ln = -1;
      de = 48'd0; dn = 48'd0; ce = 6'd0; cn = 6'd0;
      forever begin
         if (rv_e && le < 0) begin le = k; de = rd_e; ce = rc_e; end
         if (rv_n && ln < 0) begin ln = k; dn = rd_n; cn = rc_n; end
         if ((le >= 0 && ln >= 0) || k >= 60) break;
         @(posedge clk); #1;
         k++;
      end
      chk({name, " data_e"}, {16'd0, de}, {16'd0, exp_d});
      chk({name, " count_e"}, {58'd0, ce}, 64'(exp_c));
      chk({name, " lat_e"}, 64'(le), 64'(exp_le));
      chk({name, " data_n"}, {16'd0, dn}, {16'd0, exp_d});
      chk({name, " count_n"}, {58'd0, cn}, 64'(exp_c));
      chk({name, " lat_n"}, 64'(ln), 64'(exp_ln));
      got = de;
   endtask

   initial begin
      word_t      got, v, m, pk;
      logic [31:0] a, b, c, d;
      int         g;
      logic       seen;

      n_vec = 0;
      n_bad = 0;

      //               op    val                 mask                data                cnt lat_e lat_n
      tbl[0]  = '{1'b0, 48'h0000_0000_00A0, 48'h0000_0000_00F0, 48'hA000_0000_0000, 4,  8, 48};
      tbl[1]  = '{1'b1, 48'hA000_0000_0000, 48'h0000_0000_00F0, 48'h0000_0000_00A0, 4, 44, 48};
      tbl[2]  = '{1'b0, 48'h1234_5678_9ABC, 48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 48, 48, 48};
      tbl[3]  = '{1'b1, 48'h1234_5678_9ABC, 48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 48, 48, 48};
      tbl[4]  = '{1'b0, 48'h1234_5678_9ABC, 48'h0000_0000_0000, 48'h0000_0000_0000, 0,  0,  0};
      tbl[5]  = '{1'b1, 48'h1234_5678_9ABC, 48'h0000_0000_0000, 48'h0000_0000_0000, 0,  0,  0};
      tbl[6]  = '{1'b0, 48'h0000_0000_0001, 48'h0000_0000_0001, 48'h8000_0000_0000, 1,  1, 48};
      tbl[7]  = '{1'b0, 48'hFFFF_FFFF_FFFE, 48'h0000_0000_0001, 48'h0000_0000_0000, 1,  1, 48};
      tbl[8]  = '{1'b1, 48'h8000_0000_0000, 48'h8000_0000_0000, 48'h8000_0000_0000, 1,  1, 48};
      tbl[9]  = '{1'b1, 48'h8000_0000_0000, 48'h0000_0000_0001, 48'h0000_0000_0001, 1, 48, 48};
      tbl[10] = '{1'b0, 48'h0000_0000_0001, 48'h8000_0000_0001, 48'h4000_0000_0000, 2, 48, 48};
      tbl[11] = '{1'b1, 48'hC000_0000_0000, 48'h0000_0F00_0000, 48'h0000_0C00_0000, 4, 24, 48};
      tbl[12] = '{1'b0, 48'h0000_0500_0000, 48'h0000_0F00_0000, 48'h5000_0000_0000, 4, 28, 48};

      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_op    = 1'b0;
      req_val   = 48'd0;
      req_mask  = 48'd0;
      rsp_ready = 1'b1;

      // Reset values
      #12;
      chk("rst req_ready", {63'd0, rr_e}, 64'd1);
      chk("rst rsp_valid", {63'd0, rv_e}, 64'd0);
      chk("rst busy", {63'd0, busy_e}, 64'd0);
      chk("rst rsp_data", {16'd0, rd_e}, 64'd0);
      chk("rst rsp_count", {58'd0, rc_e}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 13; i++) begin
         run_txn($sformatf("vec%0d", i), tbl[i].op, tbl[i].val, tbl[i].mask,
                 tbl[i].data, tbl[i].cnt, tbl[i].lat_e, tbl[i].lat_n, got);
      end

      // Random PACK then UNPACK round trip must give val & mask
      for (int r = 0; r < 4; r++) begin
         a = $urandom; b = $urandom; c = $urandom; d = $urandom;
         v = {a[15:0], b};
         m = {c[15:0], d} & {d[15:0], c};
         if (m == 48'd0) m = 48'h0000_0010_0001;
         pk = model_pack(v, m);
         run_txn($sformatf("rnd%0d pack", r), 1'b0, v, m, pk, $countones(m),
                 model_lat(1'b0, m), 48, got);
         run_txn($sformatf("rnd%0d unpack", r), 1'b1, got, m, v & m, $countones(m),
                 model_lat(1'b1, m), 48, got);
      end

      // Backpressure: result held in DONE, new requests ignored
      wait_idle("bp");
      @(negedge clk);
      req_valid = 1'b1; req_op = 1'b0;
      req_val = 48'h0000_0000_00A0; req_mask = 48'h0000_0000_00F0;
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      g = 0;
      while (!rv_e && g < 60) begin
         @(posedge clk); #1;
         g++;
      end
      chk("bp latency", 64'(g), 64'd8);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         req_valid = 1'b1; req_op = 1'b1;
         req_val = 48'hFFFF_FFFF_FFFF; req_mask = 48'hFFFF_FFFF_FFFF;
         @(posedge clk); #1;
         chk($sformatf("bp data %0d", i), {16'd0, rd_e}, {16'd0, 48'hA000_0000_0000});
         chk($sformatf("bp valid %0d", i), {61'd0, rv_e, rr_e, busy_e}, 64'h5);
      end
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp released", {62'd0, rv_e, rr_e}, 64'h1);

      // Reset pulse mid-RUN discards the operation
      wait_idle("rst");
      @(negedge clk);
      req_valid = 1'b1; req_op = 1'b1;
      req_val = 48'hA000_0000_0000; req_mask = 48'h0000_0000_00F0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      chk("pre-rst busy", {62'd0, busy_e, busy_n}, 64'h3);
      rst_n = 1'b0;
      #1;
      chk("midrst e", {16'd0, rd_e}, 64'd0);
      chk("midrst n", {16'd0, rd_n}, 64'd0);
      chk("midrst flags e", {57'd0, rr_e, rv_e, busy_e, rc_e[3:0]}, 64'h40);
      chk("midrst flags n", {57'd0, rr_n, rv_n, busy_n, rc_n[3:0]}, 64'h40);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (rv_e || rv_n) seen = 1'b1;
      end
      chk("no rsp after rst", {63'd0, seen}, 64'd0);
      run_txn("post-rst", tbl[1].op, tbl[1].val, tbl[1].mask,
              tbl[1].data, tbl[1].cnt, tbl[1].lat_e, tbl[1].lat_n, got);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
